// File: rtl/fmult_if.sv
// rtl/fmult_if.sv - operand/result bundle for the fmult multiplier
interface fmult_if;
    logic [15:0] I16_TC;
    logic [10:0] I11_FL;
    logic        I_VALID;
    logic [15:0] O16_TC;
    logic        O_VALID;

    modport master (
        output I16_TC,
        output I11_FL,
        output I_VALID,
        input  O16_TC,
        input  O_VALID
    );

    modport slave (
        input  I16_TC,
        input  I11_FL,
        input  I_VALID,
        output O16_TC,
        output O_VALID
    );
endinterface

// File: rtl/fmult.sv
// rtl/fmult.sv - coefficient x floating-point signal multiplier; FMULT_INREG_EN adds an input register stage
module fmult (
    input  logic    CLK,
    input  logic    RESET_N,
    fmult_if.slave  bus
);

    logic [15:0] in_tc;
    logic [10:0] in_fl;
    logic        in_vld;

`ifdef FMULT_INREG_EN
    logic [15:0] tc_q;
    logic [10:0] fl_q;
    logic        vld_q;

    // Optional input stage: costs one cycle of latency, keeps one result per cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tc_q  <= 16'h0000;
            fl_q  <= 11'h000;
            vld_q <= 1'b0;
        end else begin
            tc_q  <= bus.I16_TC;
            fl_q  <= bus.I11_FL;
            vld_q <= bus.I_VALID;
        end
    end

    assign in_tc  = tc_q;
    assign in_fl  = fl_q;
    assign in_vld = vld_q;
`else
    assign in_tc  = bus.I16_TC;
    assign in_fl  = bus.I11_FL;
    assign in_vld = bus.I_VALID;
`endif

    logic        an_s;
    logic [15:0] an_shr;
    logic [12:0] an_mag;
    logic [3:0]  an_exp;
    logic [5:0]  an_mant;
    logic        sr_s;
    logic [3:0]  sr_exp;
    logic [5:0]  sr_mant;
    logic        wan_s;
    logic [4:0]  wan_exp;
    logic [12:0] mant_prod;
    logic [7:0]  wan_mant;
    logic [14:0] wan_sh;
    logic [14:0] wan_mag;
    logic [15:0] o16_d;
    logic [15:0] o16_q;
    logic        ovld_q;

    // Convert An to sign/exponent/mantissa, multiply with SR and rescale to fixed point
    always_comb begin
        an_s    = in_tc[15];
        an_shr  = $signed(in_tc) >>> 2;
        an_mag  = an_s ? 13'(-an_shr) : 13'(an_shr);

        an_exp  = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (an_mag[i]) begin
                an_exp = 4'(i + 1);
            end
        end

        // A zero magnitude has no leading one; 32 stands in as the normalised mantissa
        an_mant = (an_mag == 13'd0) ? 6'd32 : 6'(({an_mag, 6'b000000}) >> an_exp);

        sr_s    = in_fl[10];
        sr_exp  = in_fl[9:6];
        sr_mant = in_fl[5:0];

        wan_s     = sr_s ^ an_s;
        wan_exp   = {1'b0, sr_exp} + {1'b0, an_exp};
        mant_prod = {7'b0000000, sr_mant} * {7'b0000000, an_mant};
        wan_mant  = 8'((mant_prod + 13'd48) >> 4);
        wan_sh    = {wan_mant, 7'b0000000};

        // Exponents above 26 shift left; the 15-bit width drops the overflow bits
        if (wan_exp <= 5'd26) begin
            wan_mag = wan_sh >> (5'd26 - wan_exp);
        end else begin
            wan_mag = wan_sh << (wan_exp - 5'd26);
        end

        // A negative zero magnitude is reported as plain zero
        if (wan_s && (wan_mag != 15'd0)) begin
            o16_d = -{1'b0, wan_mag};
        end else begin
            o16_d = {1'b0, wan_mag};
        end
    end

    // Result register: loads only on valid input, otherwise holds the last product
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            o16_q  <= 16'h0000;
            ovld_q <= 1'b0;
        end else begin
            ovld_q <= in_vld;
            if (in_vld) begin
                o16_q <= o16_d;
            end
        end
    end

    assign bus.O16_TC  = o16_q;
    assign bus.O_VALID = ovld_q;

endmodule

// File: tb/tb_fmult.sv
// tb/tb_fmult.sv - scoreboard bench for fmult, directed vectors, both latency builds
module tb_fmult;

`ifdef FMULT_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NV = 9;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    fmult_if bus();

    fmult dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [15:0] v_tc  [NV];
    logic [10:0] v_fl  [NV];
    logic [15:0] v_exp [NV];

    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [15:0] tc, input logic [10:0] fl, input logic [15:0] e);
        exp_t x;
        @(negedge CLK);
        bus.I16_TC  = tc;
        bus.I11_FL  = fl;
        bus.I_VALID = 1'b1;
        x.val = e;
        x.due = cyc + LAT;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            bus.I_VALID = 1'b0;
        end
    endtask

    // Monitor: every presented result must match the oldest expectation, on its due cycle
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RESET_N) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_result: got no O_VALID, expected %h at cycle %0d", e.val, e.due);
            end
            if (bus.O_VALID) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got O_VALID=1 O16_TC=%h, expected O_VALID=0 (cycle %0d)", bus.O16_TC, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result", {16'h0, bus.O16_TC}, {16'h0, e.val});
                    chk("latency_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        v_tc[0] = 16'h0000; v_fl[0] = 11'h000; v_exp[0] = 16'h0000;
        v_tc[1] = 16'h4000; v_fl[1] = 11'h2A0; v_exp[1] = 16'h0430;
        v_tc[2] = 16'hC000; v_fl[2] = 11'h2A0; v_exp[2] = 16'hFBD0;
        v_tc[3] = 16'h4000; v_fl[3] = 11'h6A0; v_exp[3] = 16'hFBD0;
        v_tc[4] = 16'hC000; v_fl[4] = 11'h6A0; v_exp[4] = 16'h0430;
        v_tc[5] = 16'h7FFF; v_fl[5] = 11'h3FF; v_exp[5] = 16'h7600;
        v_tc[6] = 16'h8000; v_fl[6] = 11'h2A0; v_exp[6] = 16'h0000;
        v_tc[7] = 16'h4000; v_fl[7] = 11'h360; v_exp[7] = 16'h2180;
        v_tc[8] = 16'h4000; v_fl[8] = 11'h3A0; v_exp[8] = 16'h4300;

        bus.I16_TC  = 16'h4000;
        bus.I11_FL  = 11'h2A0;
        bus.I_VALID = 1'b1;
        #27;
        chk("reset_o16", {16'h0, bus.O16_TC}, 32'h0);
        chk("reset_ovalid", {31'h0, bus.O_VALID}, 32'h0);
        @(negedge CLK);
        bus.I_VALID = 1'b0;
        #2 RESET_N = 1'b1;

        for (int i = 0; i < NV; i++) issue(v_tc[i], v_fl[i], v_exp[i]);
        idle(LAT + 2);
        chk("hold_o16", {16'h0, bus.O16_TC}, {16'h0, v_exp[NV-1]});
        chk("hold_ovalid", {31'h0, bus.O_VALID}, 32'h0);

        for (int i = 1; i < 4; i++) issue(v_tc[i], v_fl[i], v_exp[i]);
        #2 RESET_N = 1'b0;
        sb.delete();
        #1;
        chk("midreset_o16", {16'h0, bus.O16_TC}, 32'h0);
        chk("midreset_ovalid", {31'h0, bus.O_VALID}, 32'h0);
        repeat (2) @(negedge CLK);
        chk("inreset_ovalid", {31'h0, bus.O_VALID}, 32'h0);
        bus.I_VALID = 1'b0;
        #2 RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("postreset_idle_ovalid", {31'h0, bus.O_VALID}, 32'h0);
        end

        issue(v_tc[5], v_fl[5], v_exp[5]);
        issue(v_tc[4], v_fl[4], v_exp[4]);
        idle(LAT + 2);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmult.md
FMULT -- requirements
Module: fmult

Interface
REQ-001 The block SHALL have ports CLK, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-002 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port I16_TC, input, 16 bits: predictor coefficient An, two's complement.
REQ-004 The block SHALL have port I11_FL, input, 11 bits: floating-point signal SR, packed {sign[10], exp[9:6], mant[5:0]}.
REQ-005 The block SHALL have port I_VALID, input, 1 bit: I16_TC and I11_FL are valid this cycle.
REQ-006 The block SHALL have port O16_TC, output, 16 bits: product WAn, two's complement.
REQ-007 The block SHALL have port O_VALID, output, 1 bit: O16_TC holds a new result.

Function
REQ-008 The block SHALL compute AnS = I16_TC[15].
REQ-009 The block SHALL compute AnMAG = AnS ? (-(I16_TC>>>2)) & 8191 : I16_TC>>2, a 13-bit value.
REQ-010 The block SHALL compute AnEXP = bit length of AnMAG (0 when AnMAG=0, max 13).
REQ-011 The block SHALL compute AnMANT = 32 when AnMAG=0, else (AnMAG<<6)>>AnEXP, a 6-bit value.
REQ-012 The block SHALL decode SrS = I11_FL[10], SrEXP = I11_FL[9:6] and SrMANT = I11_FL[5:0].
REQ-013 The block SHALL compute WAnS = SrS ^ AnS and WAnEXP = SrEXP + AnEXP (5 bits, 0..28).
REQ-014 The block SHALL compute WAnMANT = (SrMANT*AnMANT + 48) >> 4, an unsigned 8-bit value.
REQ-015 The block SHALL compute WAnMAG = (WAnMANT<<7) >> (26-WAnEXP) when WAnEXP<=26, else ((WAnMANT<<7) << (WAnEXP-26)) & 32767.
REQ-016 The block SHALL output WAn = WAnS ? -WAnMAG : WAnMAG, truncated to 16 bits.
REQ-017 The block SHALL treat a negative zero result (WAnS=1, WAnMAG=0) as output 0x0000.
REQ-018 The block SHALL have a latency of 1 cycle: inputs sampled at edge N with I_VALID=1 produce O16_TC and O_VALID=1 after edge N.
REQ-019 The block SHALL set O_VALID=0 after any edge where I_VALID=0, and O16_TC SHALL then hold its last value.
REQ-020 The block SHALL accept back-to-back I_VALID every cycle, giving full throughput with no stall or backpressure.

Reset
REQ-021 While RESET_N=0, O16_TC SHALL be 0x0000 and O_VALID SHALL be 0, immediately and independent of CLK.
REQ-022 A reset asserted mid-operation SHALL discard any in-flight result; the first valid output after release comes from the first I_VALID sampled after release.

Configuration
REQ-023 With macro FMULT_INREG_EN defined, I16_TC, I11_FL and I_VALID SHALL additionally be registered (reset to 0), making the latency 2 cycles at unchanged throughput.
REQ-024 Without FMULT_INREG_EN, the latency SHALL be 1 cycle; the arithmetic results SHALL be identical in both builds.

Verification
REQ-025 The bench SHALL check: I16_TC=0x0000, I11_FL=0x000, I_VALID=1 -> O16_TC=0x0000, O_VALID=1 one cycle later.
REQ-026 The bench SHALL check: I16_TC=0x4000, I11_FL=0x2A0 -> O16_TC=0x0430 (1072).
REQ-027 The bench SHALL check: I16_TC=0xC000, I11_FL=0x2A0 -> 0xFBD0, and I16_TC=0x4000, I11_FL=0x6A0 -> 0xFBD0.
REQ-028 The bench SHALL check: I16_TC=0xC000, I11_FL=0x6A0 -> 0x0430.
REQ-029 The bench SHALL check the overflow mask: I16_TC=0x7FFF, I11_FL=0x3FF -> 0x7600 (30208).
REQ-030 The bench SHALL check reset and handshake: stream the vectors above back-to-back, assert RESET_N=0 mid-stream -> O16_TC=0 and O_VALID=0 at once; after release, drive I_VALID=0 -> O_VALID stays 0.
REQ-031 The bench SHALL repeat all checks with FMULT_INREG_EN defined and confirm 2-cycle latency.
